// File: rtl/cond_unit_if.sv
// Decoder/ALU-side bundle for the condition unit: instruction controls in,
// gated writes, status flags and optional statistics counters out.
interface cond_unit_if #(parameter int CNT_W = 16);
  logic             valid_i;
  logic             flush_i;
  logic [3:0]       cond_i;
  logic [1:0]       flagw_i;
  logic             pcs_i;
  logic             regw_i;
  logic             memw_i;
  logic [3:0]       alu_flags_i;
  logic [3:0]       flags_o;
  logic             cond_ex_o;
  logic             pcsrc_o;
  logic             regwrite_o;
  logic             memwrite_o;
  logic [CNT_W-1:0] exec_cnt_o;
  logic [CNT_W-1:0] skip_cnt_o;

  modport slave (
    input  valid_i, flush_i, cond_i, flagw_i, pcs_i, regw_i, memw_i, alu_flags_i,
    output flags_o, cond_ex_o, pcsrc_o, regwrite_o, memwrite_o, exec_cnt_o, skip_cnt_o
  );

  modport master (
    output valid_i, flush_i, cond_i, flagw_i, pcs_i, regw_i, memw_i, alu_flags_i,
    input  flags_o, cond_ex_o, pcsrc_o, regwrite_o, memwrite_o, exec_cnt_o, skip_cnt_o
  );
endinterface

// File: rtl/cond_unit.sv
// ARMv4 condition unit: CNVZ status register, condition check, write gating.
// Optional executed/skipped counters are built when COND_STATS_EN is defined.
module cond_unit #(
  parameter int CNT_W = 16
) (
  input logic       clk,
  input logic       rst,
  cond_unit_if.slave bus
);

  logic [3:0] flags;
  logic       c, n, v, z;
  logic       pass;
  logic       valid_live;
  logic       exec;

  // Register layout is CNVZ: [3]=C [2]=N [1]=V [0]=Z
  assign c = flags[3];
  assign n = flags[2];
  assign v = flags[1];
  assign z = flags[0];

  always_comb begin
    pass = 1'b0;
    case (bus.cond_i)
      4'b0000: pass = z;
      4'b0001: pass = ~z;
      4'b0010: pass = c;
      4'b0011: pass = ~c;
      4'b0100: pass = n;
      4'b0101: pass = ~n;
      4'b0110: pass = v;
      4'b0111: pass = ~v;
      4'b1000: pass = c & ~z;
      4'b1001: pass = ~c | z;
      4'b1010: pass = (n == v);
      4'b1011: pass = (n != v);
      4'b1100: pass = ~z & (n == v);
      4'b1101: pass = z | (n != v);
      4'b1110: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

  assign valid_live     = bus.valid_i & ~bus.flush_i;
  assign exec           = valid_live & pass;
  assign bus.cond_ex_o  = exec;
  assign bus.pcsrc_o    = bus.pcs_i & exec;
  assign bus.regwrite_o = bus.regw_i & exec;
  assign bus.memwrite_o = bus.memw_i & exec;
  assign bus.flags_o    = flags;

  always_ff @(posedge clk) begin
    if (rst) begin
      flags <= 4'b0000;
    end else if (exec) begin
      if (bus.flagw_i[1]) begin
        flags[2] <= bus.alu_flags_i[2];
        flags[0] <= bus.alu_flags_i[0];
      end
      if (bus.flagw_i[0]) begin
        flags[3] <= bus.alu_flags_i[3];
        flags[1] <= bus.alu_flags_i[1];
      end
    end
  end

`ifdef COND_STATS_EN
  logic [CNT_W-1:0] exec_cnt;
  logic [CNT_W-1:0] skip_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      exec_cnt <= '0;
      skip_cnt <= '0;
    end else begin
      if (exec)               exec_cnt <= exec_cnt + 1'b1;
      if (valid_live & ~pass) skip_cnt <= skip_cnt + 1'b1;
    end
  end

  assign bus.exec_cnt_o = exec_cnt;
  assign bus.skip_cnt_o = skip_cnt;
`else
  assign bus.exec_cnt_o = {CNT_W{1'b0}};
  assign bus.skip_cnt_o = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_cond_unit.sv
// Directed + random bench for cond_unit with an expectation queue.
module tb_cond_unit;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cond_unit_if #(.CNT_W(CW)) bus ();
  cond_unit #(.CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic          ex;
    logic          pc;
    logic          rw;
    logic          mw;
    logic [3:0]    fl;
    logic [CW-1:0] ec;
    logic [CW-1:0] sc;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  logic [3:0]    m_flags;
  logic [CW-1:0] m_ec, m_sc;

  function automatic logic ref_pass(input logic [3:0] cc, input logic [3:0] f);
    logic fc, fn, fv, fz;
    {fc, fn, fv, fz} = f;
    case (cc)
      4'h0: return fz;
      4'h1: return !fz;
      4'h2: return fc;
      4'h3: return !fc;
      4'h4: return fn;
      4'h5: return !fn;
      4'h6: return fv;
      4'h7: return !fv;
      4'h8: return fc && !fz;
      4'h9: return !fc || fz;
      4'hA: return fn == fv;
      4'hB: return fn != fv;
      4'hC: return !fz && (fn == fv);
      4'hD: return fz || (fn != fv);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One instruction per cycle: drive after the edge, check mid-cycle, model the edge.
  task automatic step(input logic r, input logic v, input logic f, input logic [3:0] cc,
                      input logic [1:0] fw, input logic p, input logic rg, input logic m,
                      input logic [3:0] af);
    exp_t e, got;
    logic ps, ex;
    @(posedge clk);
    #1;
    rst = r;
    bus.valid_i = v; bus.flush_i = f; bus.cond_i = cc; bus.flagw_i = fw;
    bus.pcs_i = p; bus.regw_i = rg; bus.memw_i = m; bus.alu_flags_i = af;
    ps = ref_pass(cc, m_flags);
    ex = v && !f && ps;
    e.ex = ex; e.pc = p && ex; e.rw = rg && ex; e.mw = m && ex;
    e.fl = m_flags; e.ec = m_ec; e.sc = m_sc;
    q.push_back(e);
    #3;
    got = q.pop_front();
    chk("cond_ex",  {7'd0, bus.cond_ex_o},  {7'd0, got.ex});
    chk("pcsrc",    {7'd0, bus.pcsrc_o},    {7'd0, got.pc});
    chk("regwrite", {7'd0, bus.regwrite_o}, {7'd0, got.rw});
    chk("memwrite", {7'd0, bus.memwrite_o}, {7'd0, got.mw});
    chk("flags",    {4'd0, bus.flags_o},    {4'd0, got.fl});
    chk("exec_cnt", {4'd0, bus.exec_cnt_o}, {4'd0, got.ec});
    chk("skip_cnt", {4'd0, bus.skip_cnt_o}, {4'd0, got.sc});
    if (r) begin
      m_flags = 4'b0000;
`ifdef COND_STATS_EN
      m_ec = '0; m_sc = '0;
`endif
    end else begin
      if (ex && fw[1]) begin m_flags[2] = af[2]; m_flags[0] = af[0]; end
      if (ex && fw[0]) begin m_flags[3] = af[3]; m_flags[1] = af[1]; end
`ifdef COND_STATS_EN
      if (ex) m_ec = m_ec + 1'b1;
      if (v && !f && !ps) m_sc = m_sc + 1'b1;
`endif
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 4'hE, 2'b00, 1'b0, 1'b0, 1'b0, 4'h0);
  endtask

  initial begin
    logic [3:0] ri;
    bus.valid_i = 0; bus.flush_i = 0; bus.cond_i = 4'hE; bus.flagw_i = 0;
    bus.pcs_i = 0; bus.regw_i = 0; bus.memw_i = 0; bus.alu_flags_i = 0;
    m_flags = 4'b0000; m_ec = '0; m_sc = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state and first conditions
    step(0, 1, 0, 4'h0, 2'b00, 0, 0, 0, 4'h0);
    chk("rst_flags", {4'd0, bus.flags_o}, 8'h00);
    chk("eq_after_rst", {7'd0, bus.cond_ex_o}, 8'h00);
    step(0, 1, 0, 4'hE, 2'b00, 1, 1, 1, 4'h0);
    chk("al_after_rst", {7'd0, bus.cond_ex_o}, 8'h01);
    chk("al_pcsrc", {7'd0, bus.pcsrc_o}, 8'h01);

    // CMP-like full flag write, then EQ/NE
    step(0, 1, 0, 4'hE, 2'b11, 0, 0, 0, 4'b0001);
    step(0, 1, 0, 4'h0, 2'b00, 0, 1, 0, 4'h0);
    chk("cmp_flags", {4'd0, bus.flags_o}, 8'h01);
    chk("eq_regwrite", {7'd0, bus.regwrite_o}, 8'h01);
    step(0, 1, 0, 4'h1, 2'b00, 0, 1, 0, 4'h0);
    chk("ne_regwrite", {7'd0, bus.regwrite_o}, 8'h00);

    // Partial write: NZ only
    step(0, 1, 0, 4'hE, 2'b11, 0, 0, 0, 4'b1111);
    step(0, 1, 0, 4'hE, 2'b10, 0, 0, 0, 4'b0000);
    idle();
    chk("partial_nz", {4'd0, bus.flags_o}, 8'h0A);
    step(0, 1, 0, 4'hE, 2'b01, 0, 0, 0, 4'b0000);
    idle();
    chk("partial_cv", {4'd0, bus.flags_o}, 8'h00);

    // Signed compares with N=1 V=0
    step(0, 1, 0, 4'hE, 2'b11, 0, 0, 0, 4'b0100);
    step(0, 1, 0, 4'hB, 2'b00, 0, 0, 0, 4'h0); chk("lt_n1v0", {7'd0, bus.cond_ex_o}, 8'h01);
    step(0, 1, 0, 4'hA, 2'b00, 0, 0, 0, 4'h0); chk("ge_n1v0", {7'd0, bus.cond_ex_o}, 8'h00);
    step(0, 1, 0, 4'hC, 2'b00, 0, 0, 0, 4'h0); chk("gt_n1v0", {7'd0, bus.cond_ex_o}, 8'h00);
    step(0, 1, 0, 4'hD, 2'b00, 0, 0, 0, 4'h0); chk("le_n1v0", {7'd0, bus.cond_ex_o}, 8'h01);
    step(0, 1, 0, 4'hE, 2'b11, 0, 0, 0, 4'b0110);
    step(0, 1, 0, 4'hA, 2'b00, 0, 0, 0, 4'h0); chk("ge_n1v1", {7'd0, bus.cond_ex_o}, 8'h01);

    // NV never executes, under every flag value
    for (int i = 0; i < 16; i++) begin
      ri = i[3:0];
      step(0, 1, 0, 4'hE, 2'b11, 0, 0, 0, ri);
      step(0, 1, 0, 4'hF, 2'b11, 1, 1, 1, ~ri);
      chk("nv_never", {7'd0, bus.cond_ex_o}, 8'h00);
    end

    // Suppression: flush, failed condition, bubble
    step(0, 1, 0, 4'hE, 2'b11, 0, 0, 0, 4'b0110);
    step(0, 1, 1, 4'hE, 2'b11, 0, 0, 1, 4'b1001);
    chk("flush_memwrite", {7'd0, bus.memwrite_o}, 8'h00);
    step(0, 1, 0, 4'h0, 2'b11, 0, 0, 0, 4'b1001);
    chk("flush_flags", {4'd0, bus.flags_o}, 8'h06);
    step(0, 0, 0, 4'hE, 2'b11, 0, 0, 0, 4'b1001);
    chk("condfail_flags", {4'd0, bus.flags_o}, 8'h06);
    idle();
    chk("bubble_flags", {4'd0, bus.flags_o}, 8'h06);

    // Reset beats a valid instruction with a flag write
    step(1, 1, 0, 4'hE, 2'b11, 0, 1, 0, 4'b1111);
    idle();
    chk("rst_wins_flags", {4'd0, bus.flags_o}, 8'h00);

    // Statistics: 15 executed, 3 skipped, then wrap and reset
    step(1, 0, 0, 4'hE, 2'b00, 0, 0, 0, 4'h0);
    repeat (15) step(0, 1, 0, 4'hE, 2'b00, 0, 0, 0, 4'h0);
    repeat (3)  step(0, 1, 0, 4'hF, 2'b00, 0, 0, 0, 4'h0);
    idle();
`ifdef COND_STATS_EN
    chk("exec_15", {4'd0, bus.exec_cnt_o}, 8'd15);
    chk("skip_3",  {4'd0, bus.skip_cnt_o}, 8'd3);
`else
    chk("exec_tied", {4'd0, bus.exec_cnt_o}, 8'd0);
    chk("skip_tied", {4'd0, bus.skip_cnt_o}, 8'd0);
`endif
    step(0, 1, 0, 4'hE, 2'b00, 0, 0, 0, 4'h0);
    idle();
    chk("exec_wrap", {4'd0, bus.exec_cnt_o}, 8'd0);
    step(0, 1, 1, 4'hF, 2'b00, 0, 0, 0, 4'h0);
    step(1, 0, 0, 4'hE, 2'b00, 0, 0, 0, 4'h0);
    idle();
    chk("cnt_rst_exec", {4'd0, bus.exec_cnt_o}, 8'd0);
    chk("cnt_rst_skip", {4'd0, bus.skip_cnt_o}, 8'd0);

    // Random mix against the reference model
    for (int k = 0; k < 200; k++) begin
      step(($urandom_range(0, 31) == 0), 1'($urandom), ($urandom_range(0, 7) == 0),
           4'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           4'($urandom));
    end
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
